ysyx_bus_arb: RTL

- Two-master, one-slave arbiter that shares the single downstream memory port between the L1I refill engine and the L1D load/store engine.
- L1I issues INCR burst line refills; L1D issues single-beat loads and single-beat stores.
- Sits between the L1 caches and the SoC bus bridge, and runs exactly one transaction at a time.
- Grants are round-robin when both caches request in the same cycle.

---
 rtl/ysyx_bus_arb.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_bus_arb.sv
// Two-master (L1I refill / L1D load-store), one-slave memory port arbiter.
// One transaction in flight at a time; simultaneous requests alternate round-robin.
module ysyx_bus_arb #(
    parameter int XLEN    = 32,
    parameter int I_BURST = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            i_arvalid,
    input  logic [XLEN-1:0] i_araddr,
    output logic            i_bus_ready,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_rvalid,
    output logic            i_rlast,

    input  logic            d_arvalid,
    input  logic [XLEN-1:0] d_araddr,
    input  logic [7:0]      d_rstrb,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    input  logic            d_awvalid,
    input  logic [XLEN-1:0] d_awaddr,
    input  logic [7:0]      d_wstrb,
    input  logic            d_wvalid,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_wready,

    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [XLEN-1:0] m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    input  logic            m_rvalid,
    input  logic [XLEN-1:0] m_rdata,
    input  logic            m_rlast,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [XLEN-1:0] m_awaddr,
    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_wstrb,
    input  logic            m_bvalid
);

    typedef enum logic [2:0] {
        IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B
    } state_e;

    state_e          state_q, state_d;
    logic            lastGrantD_q;
    logic [XLEN-1:0] arAddr_q;
    logic [7:0]      arLen_q;
    logic [2:0]      arSize_q;
    logic [XLEN-1:0] awAddr_q;
    logic [XLEN-1:0] wData_q;
    logic [3:0]      wStrb_q;
    logic [XLEN-1:0] iRdata_q;
    logic            iRvalid_q;
    logic            iRlast_q;
    logic [XLEN-1:0] dRdata_q;
    logic            dRvalid_q;
    logic            dWready_q;

    logic            dStore;
    logic            dReq;
    logic            grantI;
    logic            grantD;
    logic [2:0]      dSize;
    logic            unusedStrbHi;

    assign dStore = d_awvalid & d_wvalid;
    assign dReq   = d_arvalid | dStore;
    // On a tie the side that did not win last time gets the port.
    assign grantI = (state_q == IDLE) & i_arvalid & (~dReq | lastGrantD_q);
    assign grantD = (state_q == IDLE) & dReq & (~i_arvalid | ~lastGrantD_q);
    assign dSize  = (d_rstrb == 8'h01) ? 3'd0 :
                    (d_rstrb == 8'h03) ? 3'd1 : 3'd2;
    assign unusedStrbHi = ^d_wstrb[7:4];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grantI) begin
                    state_d = I_AR;
                end else if (grantD) begin
                    state_d = dStore ? D_W : D_AR;
                end
            end
            I_AR:    if (m_arready)            state_d = I_R;
            I_R:     if (m_rvalid && m_rlast)  state_d = IDLE;
            D_AR:    if (m_arready)            state_d = D_R;
            D_R:     if (m_rvalid)             state_d = IDLE;
            D_W:     if (m_awready)            state_d = D_B;
            D_B:     if (m_bvalid)             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        i_bus_ready = (state_q == IDLE);
        m_arvalid   = (state_q == I_AR) || (state_q == D_AR);
        m_awvalid   = (state_q == D_W);
    end

    // Request payload is captured only at grant, so it stays stable until handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lastGrantD_q <= 1'b1;
            arAddr_q     <= '0;
            arLen_q      <= '0;
            arSize_q     <= '0;
            awAddr_q     <= '0;
            wData_q      <= '0;
            wStrb_q      <= '0;
        end else if (grantI) begin
            lastGrantD_q <= 1'b0;
            arAddr_q     <= i_araddr;
            arLen_q      <= 8'(I_BURST - 1);
            arSize_q     <= 3'd2;
        end else if (grantD) begin
            lastGrantD_q <= 1'b1;
            if (dStore) begin
                awAddr_q <= d_awaddr;
                wStrb_q  <= d_wstrb[3:0] << d_awaddr[1:0];
                wData_q  <= d_wdata << {d_awaddr[1:0], 3'b000};
            end else begin
                arAddr_q <= d_araddr;
                arLen_q  <= 8'd0;
                arSize_q <= dSize;
            end
        end
    end

    // Responses are only honoured in the state that expects them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iRdata_q  <= '0;
            iRvalid_q <= 1'b0;
            iRlast_q  <= 1'b0;
            dRdata_q  <= '0;
            dRvalid_q <= 1'b0;
            dWready_q <= 1'b0;
        end else begin
            iRvalid_q <= (state_q == I_R) && m_rvalid;
            iRlast_q  <= (state_q == I_R) && m_rvalid && m_rlast;
            dRvalid_q <= (state_q == D_R) && m_rvalid;
            dWready_q <= (state_q == D_B) && m_bvalid;
            if ((state_q == I_R) && m_rvalid) begin
                iRdata_q <= m_rdata;
            end
            if ((state_q == D_R) && m_rvalid) begin
                dRdata_q <= m_rdata;
            end
        end
    end

    assign m_araddr = arAddr_q;
    assign m_arlen  = arLen_q;
    assign m_arsize = arSize_q;
    assign m_awaddr = awAddr_q;
    assign m_wdata  = wData_q;
    assign m_wstrb  = wStrb_q;
    assign i_rdata  = iRdata_q;
    assign i_rvalid = iRvalid_q;
    assign i_rlast  = iRlast_q;
    assign d_rdata  = dRdata_q;
    assign d_rvalid = dRvalid_q;
    assign d_wready = dWready_q;

endmodule
